hex_entry: RTL and testbench

//  Push-button hex entry front end: debounces four raw buttons and edits a 16-bit

---
 rtl/hex_entry.sv | 178 +++++++++++++++++
 tb/tb_hex_entry.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_entry.sv
// hex_entry: debounced four-button hex word editor with a valid/ack handoff.
// Optional inc/dec auto-repeat is built when HEX_ENTRY_REPEAT_EN is defined.
module hex_entry #(
  parameter int DB_CYCLES = 500000,
  parameter int RPT_DELAY = 25000000,
  parameter int RPT_RATE  = 5000000
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        btn_inc,
  input  logic        btn_dec,
  input  logic        btn_next,
  input  logic        btn_enter,
  input  logic        value_ack,
  output logic [0:15] value,
  output logic [1:0]  cursor,
  output logic        value_valid
);

  localparam int DW = $clog2(DB_CYCLES + 1);

  typedef enum logic {EDIT, HOLD} state_t;

  state_t        state_q, state_d;
  logic [0:15]   val_q, val_d;
  logic [1:0]    cur_q, cur_d;
  logic [3:0]    raw;
  logic [3:0]    s1_q, s2_q;
  logic [3:0]    db_q, dbp_q;
  logic [3:0]    arm_q;
  logic [3:0]    press;
  logic [1:0]    prime_q;
  logic [DW-1:0] cnt_q [4];
  logic [1:0]    rpt;
  logic          inc_ev, dec_ev;
  logic [3:0]    idx;
  logic [3:0]    nib;

  assign raw = {btn_enter, btn_next, btn_dec, btn_inc};

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      prime_q <= '0;
    end else if (prime_q != 2'd2) begin
      prime_q <= prime_q + 2'd1;
    end
  end

  // arm_q blocks the event for a button still held when clr drops
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      s1_q  <= '0;
      s2_q  <= '0;
      db_q  <= '0;
      dbp_q <= '0;
      arm_q <= '0;
      for (int b = 0; b < 4; b++) begin
        cnt_q[b] <= '0;
      end
    end else begin
      s1_q  <= raw;
      s2_q  <= s1_q;
      dbp_q <= db_q;
      for (int b = 0; b < 4; b++) begin
        if (s2_q[b] == db_q[b]) begin
          cnt_q[b] <= '0;
        end else if (cnt_q[b] == DW'(DB_CYCLES - 1)) begin
          db_q[b]  <= ~db_q[b];
          cnt_q[b] <= '0;
        end else begin
          cnt_q[b] <= cnt_q[b] + DW'(1);
        end
        if (prime_q == 2'd2 && !s2_q[b] && !db_q[b]) begin
          arm_q[b] <= 1'b1;
        end
      end
    end
  end

  assign press = db_q & ~dbp_q & arm_q;

`ifdef HEX_ENTRY_REPEAT_EN
  localparam int RMAX = (RPT_DELAY > RPT_RATE) ? RPT_DELAY : RPT_RATE;
  localparam int RW   = $clog2(RMAX + 1);

  logic [RW-1:0] rcnt_q [2];
  logic [1:0]    live_q;
  logic [1:0]    fst_q;

  always_comb begin
    rpt = '0;
    for (int b = 0; b < 2; b++) begin
      rpt[b] = live_q[b] && db_q[b] &&
               (fst_q[b] ? (rcnt_q[b] == RW'(RPT_DELAY))
                         : (rcnt_q[b] == RW'(RPT_RATE)));
    end
  end

  // rcnt_q counts cycles since the press event or the last repeat
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      live_q <= '0;
      fst_q  <= '1;
      for (int b = 0; b < 2; b++) begin
        rcnt_q[b] <= '0;
      end
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (!db_q[b] || state_q != EDIT) begin
          live_q[b] <= 1'b0;
          fst_q[b]  <= 1'b1;
          rcnt_q[b] <= '0;
        end else if (press[b]) begin
          live_q[b] <= 1'b1;
          fst_q[b]  <= 1'b1;
          rcnt_q[b] <= RW'(1);
        end else if (live_q[b]) begin
          if (rpt[b]) begin
            fst_q[b]  <= 1'b0;
            rcnt_q[b] <= RW'(1);
          end else begin
            rcnt_q[b] <= rcnt_q[b] + RW'(1);
          end
        end
      end
    end
  end
`else
  assign rpt = {2{(RPT_DELAY + RPT_RATE) < 0}};
`endif

  assign inc_ev = press[0] | rpt[0];
  assign dec_ev = press[1] | rpt[1];
  assign idx    = {cur_q, 2'b00};
  assign nib    = val_q[idx +: 4];

  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    cur_d   = cur_q;
    unique case (state_q)
      EDIT: begin
        if (press[3]) begin
          state_d = HOLD;
        end else if (press[2]) begin
          cur_d = cur_q + 2'd1;
        end else if (inc_ev) begin
          val_d[idx +: 4] = nib + 4'd1;
        end else if (dec_ev) begin
          val_d[idx +: 4] = nib - 4'd1;
        end
      end
      HOLD: begin
        if (value_ack) begin
          state_d = EDIT;
          cur_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= EDIT;
      val_q   <= '0;
      cur_q   <= '0;
    end else begin
      state_q <= state_d;
      val_q   <= val_d;
      cur_q   <= cur_d;
    end
  end

  assign value       = val_q;
  assign cursor      = cur_q;
  assign value_valid = (state_q == HOLD);

endmodule

// File: tb/tb_hex_entry.sv
// tb_hex_entry: randomized button stimulus against a nibble/cursor model.
// Build with +define+HEX_ENTRY_REPEAT_EN to check the auto-repeat variant.
module tb_hex_entry;

  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RR = 5;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [3:0]  btn = '0;
  logic        ack = 1'b0;
  logic [0:15] value;
  logic [1:0]  cursor;
  logic        valid;

  int errors = 0;
  int checks = 0;

  logic [3:0] m_nib [4];
  int         m_cur;
  bit         m_valid;

  hex_entry #(
    .DB_CYCLES(DB),
    .RPT_DELAY(RD),
    .RPT_RATE (RR)
  ) dut (
    .clk        (clk),
    .clr        (clr),
    .btn_inc    (btn[0]),
    .btn_dec    (btn[1]),
    .btn_next   (btn[2]),
    .btn_enter  (btn[3]),
    .value_ack  (ack),
    .value      (value),
    .cursor     (cursor),
    .value_valid(valid)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] m_word();
    return {m_nib[0], m_nib[1], m_nib[2], m_nib[3]};
  endfunction

  function automatic int exp_incs(input int h);
    int n;
    n = 1;
`ifdef HEX_ENTRY_REPEAT_EN
    if (h - 1 >= RD) n = n + 1 + (h - 1 - RD) / RR;
`endif
    return n;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 4; i++) m_nib[i] = 4'h0;
    m_cur   = 0;
    m_valid = 1'b0;
  endtask

  // 0=inc 1=dec 2=next 3=enter; presses while committed are dropped
  task automatic m_event(input int b);
    if (m_valid) return;
    case (b)
      0: m_nib[m_cur] = m_nib[m_cur] + 4'd1;
      1: m_nib[m_cur] = m_nib[m_cur] - 4'd1;
      2: m_cur = (m_cur + 1) % 4;
      default: m_valid = 1'b1;
    endcase
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int b, input int hold);
    btn[b] = 1'b1;
    tick(hold);
    btn[b] = 1'b0;
    tick(12);
    m_event(b);
  endtask

  task automatic do_clr();
    @(negedge clk);
    clr = 1'b1;
    tick(2);
    clr = 1'b0;
    tick(4);
    m_reset();
  endtask

  task automatic test_reset();
    m_reset();
    tick(3);
    checks++;
    if (value !== 16'h0000) begin
      errors++;
      $display("FAIL reset_value got=%h exp=0000", value);
    end
    checks++;
    if (cursor !== 2'd0 || valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl got cur=%0d vld=%b exp cur=0 vld=0", cursor, valid);
    end
    clr = 1'b0;
    tick(4);
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 10; i++) begin
      btn[0] = (i % 2 == 0);
      tick(2);
    end
    checks++;
    if (value !== 16'h0000) begin
      errors++;
      $display("FAIL bounce_glitch got=%h exp=0000", value);
    end
    btn[0] = 1'b1;
    tick(5);
    checks++;
    if (value !== 16'h0000) begin
      errors++;
      $display("FAIL bounce_early got=%h exp=0000", value);
    end
    tick(3);
    m_event(0);
    checks++;
    if (value !== m_word()) begin
      errors++;
      $display("FAIL bounce_one_inc got=%h exp=%h", value, m_word());
    end
    btn[0] = 1'b0;
    tick(12);
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 15; i++) press(0, 8);
    checks++;
    if (value !== m_word() || m_word() !== 16'h0000) begin
      errors++;
      $display("FAIL wrap_inc got=%h exp=%h", value, m_word());
    end
    press(1, 8);
    checks++;
    if (value !== m_word()) begin
      errors++;
      $display("FAIL wrap_dec got=%h exp=%h", value, m_word());
    end
    for (int i = 0; i < 4; i++) begin
      press(2, 8);
      checks++;
      if (cursor !== 2'(m_cur)) begin
        errors++;
        $display("FAIL wrap_next%0d got=%0d exp=%0d", i, cursor, m_cur);
      end
    end
  endtask

  task automatic test_edit_handshake();
    do_clr();
    for (int d = 0; d < 4; d++) begin
      for (int k = 0; k <= d; k++) press(0, 6);
      if (d < 3) press(2, 6);
    end
    press(3, 6);
    checks++;
    if (valid !== 1'b1 || value !== m_word()) begin
      errors++;
      $display("FAIL commit got vld=%b val=%h exp vld=1 val=%h", valid, value, m_word());
    end
    press(0, 6);
    press(2, 6);
    press(1, 6);
    checks++;
    if (valid !== 1'b1 || value !== m_word() || cursor !== 2'(m_cur)) begin
      errors++;
      $display("FAIL hold_ignore got vld=%b val=%h cur=%0d exp val=%h cur=%0d",
               valid, value, cursor, m_word(), m_cur);
    end
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    m_valid = 1'b0;
    m_cur   = 0;
    checks++;
    if (valid !== 1'b0 || cursor !== 2'd0 || value !== m_word()) begin
      errors++;
      $display("FAIL ack got vld=%b cur=%0d val=%h exp vld=0 cur=0 val=%h",
               valid, cursor, value, m_word());
    end
  endtask

  task automatic test_ack_on_entry();
    int hi;
    hi = 0;
    press(2, 6);
    ack = 1'b1;
    btn[3] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (valid) hi++;
    end
    btn[3] = 1'b0;
    tick(12);
    ack = 1'b0;
    m_cur = 0;
    checks++;
    if (hi !== 1) begin
      errors++;
      $display("FAIL ack_entry_len got=%0d exp=1", hi);
    end
    checks++;
    if (cursor !== 2'd0 || valid !== 1'b0 || value !== m_word()) begin
      errors++;
      $display("FAIL ack_entry_after got cur=%0d vld=%b val=%h exp cur=0 vld=0 val=%h",
               cursor, valid, value, m_word());
    end
  endtask

  task automatic test_simultaneous();
    btn[2] = 1'b1;
    btn[0] = 1'b1;
    tick(8);
    btn = '0;
    tick(12);
    m_event(2);
    checks++;
    if (cursor !== 2'(m_cur) || value !== m_word()) begin
      errors++;
      $display("FAIL simul got cur=%0d val=%h exp cur=%0d val=%h",
               cursor, value, m_cur, m_word());
    end
  endtask

  task automatic test_random();
    int b;
    for (int i = 0; i < 30; i++) begin
      b = $urandom_range(0, 2);
      press(b, $urandom_range(5, 10));
      checks++;
      if (value !== m_word() || cursor !== 2'(m_cur)) begin
        errors++;
        $display("FAIL rand%0d b=%0d got val=%h cur=%0d exp val=%h cur=%0d",
                 i, b, value, cursor, m_word(), m_cur);
      end
    end
  endtask

  task automatic test_held_reset();
    btn[0] = 1'b1;
    tick(3);
    clr = 1'b1;
    tick(2);
    clr = 1'b0;
    tick(20);
    btn[0] = 1'b0;
    tick(12);
    m_reset();
    checks++;
    if (value !== 16'h0000) begin
      errors++;
      $display("FAIL held_reset got=%h exp=0000", value);
    end
    press(0, 8);
    checks++;
    if (value !== m_word()) begin
      errors++;
      $display("FAIL held_reset_press got=%h exp=%h", value, m_word());
    end
  endtask

  task automatic test_reset_mid_hold();
    do_clr();
    press(0, 6);
    press(3, 6);
    checks++;
    if (valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_hold_enter got vld=%b exp 1", valid);
    end
    @(negedge clk);
    #2 clr = 1'b1;
    #1;
    checks++;
    if (valid !== 1'b0 || value !== 16'h0000) begin
      errors++;
      $display("FAIL mid_hold_clr got vld=%b val=%h exp vld=0 val=0000", valid, value);
    end
    tick(2);
    clr = 1'b0;
    tick(4);
    m_reset();
  endtask

  task automatic test_repeat();
    int h;
    for (int r = 0; r < 3; r++) begin
      do_clr();
      h = (r == 0) ? 41 : $urandom_range(10, 60);
      btn[0] = 1'b1;
      tick(h);
      btn[0] = 1'b0;
      tick(12);
      m_nib[0] = 4'(exp_incs(h));
      checks++;
      if (value !== m_word()) begin
        errors++;
        $display("FAIL repeat h=%0d got=%h exp=%h", h, value, m_word());
      end
    end
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_wrap();
    test_edit_handshake();
    test_ack_on_entry();
    test_simultaneous();
    test_random();
    test_held_reset();
    test_reset_mid_hold();
    test_repeat();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
